// File: rtl/lcd_sequencer_if.sv
// Bus between the requesting logic and lcd_sequencer: refresh request, BCD readout
// inputs, the byte/strobe stream towards lcd_driver, status flags and FSM state.
interface lcd_sequencer_if;
   logic        update;
   logic [11:0] temp_bcd;
   logic [11:0] light_bcd;
   logic [7:0]  lcd_data_in;
   logic        lcd_send;
   logic        rs_select;
   logic        busy;
   logic        init_done;
   logic [2:0]  state_dbg;

   // lcd_send is a single-cycle strobe with no back-pressure: lcd_data_in and rs_select are
   // valid in the strobe cycle and held until the next strobe; spacing is self-timed.
   modport master (
      output update, temp_bcd, light_bcd,
      input  lcd_data_in, lcd_send, rs_select, busy, init_done, state_dbg
   );
   modport slave (
      input  update, temp_bcd, light_bcd,
      output lcd_data_in, lcd_send, rs_select, busy, init_done, state_dbg
   );
endinterface

// File: rtl/lcd_sequencer.sv
// HD44780 8-bit init followed by on-demand two-line temperature/light readout.
// Define LCD_UNITS_EN to append unit suffixes ("C" on line 1, " lx" on line 2).
module lcd_sequencer #(
   parameter int PWR_DELAY = 750000,
   parameter int CMD_DELAY = 2500,
   parameter int CLR_DELAY = 100000,
   parameter int CNT_W     = 20
) (
   input  logic           clk,
   input  logic           rst,
   lcd_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      PWR_WAIT, INIT_SEND, INIT_WAIT, IDLE, WR_SEND, WR_WAIT
   } state_t;

`ifdef LCD_UNITS_EN
   localparam logic [4:0] LAST_IDX  = 5'd16;
   localparam logic [4:0] LINE2_IDX = 5'd8;
`else
   localparam logic [4:0] LAST_IDX  = 5'd12;
   localparam logic [4:0] LINE2_IDX = 5'd7;
`endif
   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DELAY - 1);
   localparam logic [CNT_W-1:0] CMD_CNT  = CNT_W'(CMD_DELAY);
   localparam logic [CNT_W-1:0] CLR_CNT  = CNT_W'(CLR_DELAY);

   function automatic logic [7:0] digit_ascii(input logic [3:0] d);
      return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
   endfunction

   function automatic logic [7:0] init_byte(input logic [1:0] i);
      logic [7:0] b;
      case (i)
         2'd0:    b = 8'h38;
         2'd1:    b = 8'h0C;
         2'd2:    b = 8'h06;
         default: b = 8'h01;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] wr_byte(input logic [4:0] i, input logic [11:0] t,
                                          input logic [11:0] l);
      logic [7:0] b;
      case (i)
         5'd0:    b = 8'h80;
         5'd1:    b = 8'h54;
         5'd2:    b = 8'h3D;
         5'd3:    b = digit_ascii(t[11:8]);
         5'd4:    b = digit_ascii(t[7:4]);
         5'd5:    b = 8'h2E;
         5'd6:    b = digit_ascii(t[3:0]);
`ifdef LCD_UNITS_EN
         5'd7:    b = 8'h43;
         5'd8:    b = 8'hC0;
         5'd9:    b = 8'h4C;
         5'd10:   b = 8'h3D;
         5'd11:   b = digit_ascii(l[11:8]);
         5'd12:   b = digit_ascii(l[7:4]);
         5'd13:   b = digit_ascii(l[3:0]);
         5'd14:   b = 8'h20;
         5'd15:   b = 8'h6C;
         default: b = 8'h78;
`else
         5'd7:    b = 8'hC0;
         5'd8:    b = 8'h4C;
         5'd9:    b = 8'h3D;
         5'd10:   b = digit_ascii(l[11:8]);
         5'd11:   b = digit_ascii(l[7:4]);
         default: b = digit_ascii(l[3:0]);
`endif
      endcase
      return b;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       idx_q, idx_d, nxt_idx;
   logic [7:0]       data_q, data_d;
   logic             send_q, send_d, rs_q, rs_d, busy_q, busy_d;
   logic             done_q, done_d, pend_q, pend_d, req, start_wr;
   logic [11:0]      temp_q, temp_d, light_q, light_d;

   assign req     = pend_q | bus.update;
   assign nxt_idx = idx_q + 5'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PWR_WAIT;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         send_q  <= 1'b0;
         rs_q    <= 1'b0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         pend_q  <= 1'b0;
         temp_q  <= '0;
         light_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         send_q  <= send_d;
         rs_q    <= rs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
         temp_q  <= temp_d;
         light_q <= light_d;
      end
   end

   // A finished wait with a request outstanding launches the next refresh on the same
   // edge, so a pending update costs no extra cycle beyond the normal spacing.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      data_d   = data_q;
      send_d   = 1'b0;
      rs_d     = rs_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pend_d   = req;
      temp_d   = temp_q;
      light_d  = light_q;
      start_wr = 1'b0;
      case (state_q)
         PWR_WAIT: begin
            if (cnt_q == PWR_LAST) begin
               state_d = INIT_SEND;
               idx_d   = '0;
               data_d  = init_byte(2'd0);
               rs_d    = 1'b0;
               send_d  = 1'b1;
               cnt_d   = CMD_CNT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         INIT_SEND, WR_SEND: begin
            state_d = (state_q == INIT_SEND) ? INIT_WAIT : WR_WAIT;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         end
         INIT_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (idx_q == 5'd3) begin
               done_d = 1'b1;
               if (req) begin
                  start_wr = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               state_d = INIT_SEND;
               idx_d   = nxt_idx;
               data_d  = init_byte(nxt_idx[1:0]);
               rs_d    = 1'b0;
               send_d  = 1'b1;
               cnt_d   = (idx_q == 5'd2) ? CLR_CNT : CMD_CNT;
            end
         end
         IDLE: begin
            if (req) start_wr = 1'b1;
         end
         WR_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (idx_q == LAST_IDX) begin
               if (req) begin
                  start_wr = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               state_d = WR_SEND;
               idx_d   = nxt_idx;
               data_d  = wr_byte(nxt_idx, temp_q, light_q);
               rs_d    = (nxt_idx != LINE2_IDX);
               send_d  = 1'b1;
               cnt_d   = CMD_CNT;
            end
         end
         default: state_d = PWR_WAIT;
      endcase
      if (start_wr) begin
         state_d = WR_SEND;
         temp_d  = bus.temp_bcd;
         light_d = bus.light_bcd;
         pend_d  = 1'b0;
         busy_d  = 1'b1;
         idx_d   = '0;
         data_d  = 8'h80;
         rs_d    = 1'b0;
         send_d  = 1'b1;
         cnt_d   = CMD_CNT;
      end
   end

   assign bus.lcd_data_in = data_q;
   assign bus.lcd_send    = send_q;
   assign bus.rs_select   = rs_q;
   assign bus.busy        = busy_q;
   assign bus.init_done   = done_q;
   assign bus.state_dbg   = state_q;
endmodule
